// File: rtl/opti_pkg.sv
// Shared definitions for the IIR cascade feeder.
//   DW             : default sample width of the cascade datapath
//   feeder_state_t : issue FSM state (IDLE, GAPWAIT)
package opti_pkg;

  localparam int DW = 24;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GAPWAIT = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/opti_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty detection.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : clears pointers (and level) on the next edge; wins over push/pop
//   push/wdata : write request; ignored when full
//   pop        : read request; ignored when empty
//   rdata      : head word (combinational, valid when !empty)
//   full/empty : status
//   level      : occupancy 0..DEPTH
module opti_sync_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Same index, different wrap bit -> full; identical pointers -> empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Full blocks the write even if a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/iir_sample_feeder.sv
// Paced sample transmitter for the 4-section IIR cascade.
// Buffers upstream ready/valid samples in a FIFO and issues them as
// single-cycle valid pulses at least GAP cycles apart, with at most
// MAX_INFLIGHT samples outstanding (returns counted on iir_valid_out).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   s_data/s_valid  : upstream sample stream; s_ready = !full && !flush
//   flush           : synchronous FIFO clear, suppresses that cycle's issue
//   iir_data_in     : last issued sample (changes only on issue edges)
//   iir_valid_in    : one-cycle pulse per issued sample
//   iir_valid_out   : cascade return strobe
//   level           : FIFO occupancy
//   inflight        : issued-but-not-returned count
//   issued_cnt      : total issued since reset (wraps)
//   err_underflow   : sticky, return seen with nothing in flight
module iir_sample_feeder #(
  parameter int DW           = opti_pkg::DW,
  parameter int DEPTH        = 16,
  parameter int GAP          = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DW-1:0]                   s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            flush,
  output logic [DW-1:0]                   iir_data_in,
  output logic                            iir_valid_in,
  input  logic                            iir_valid_out,
  output logic [$clog2(DEPTH):0]          level,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic [31:0]                     issued_cnt,
  output logic                            err_underflow
);

  import opti_pkg::*;

  localparam int IFW = $clog2(MAX_INFLIGHT) + 1;
  localparam int GW  = $clog2(GAP) + 1;

  feeder_state_t state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_push;
  logic          issue;
  logic          can_issue;
  logic          ret_ok;

  assign s_ready   = !fifo_full && !flush;
  assign fifo_push = s_valid && s_ready;

  opti_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .wdata (s_data),
    .pop   (issue),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign can_issue = !flush && !fifo_empty && (inflight < IFW'(MAX_INFLIGHT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Counter is loaded with GAP-1 on the issue edge and the FSM re-enters
  // IDLE on the edge it hits 0, so the next issue edge lands exactly GAP
  // edges after the previous one.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    issue     = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      gap_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            issue = 1'b1;
            if (GAP > 1) begin
              state_nxt = GAPWAIT;
              gap_nxt   = GW'(GAP - 1);
            end
          end
        end
        GAPWAIT: begin
          gap_nxt = gap_cnt - 1'b1;
          if (gap_cnt <= GW'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Returns with nothing outstanding are ignored for counting but flagged.
  assign ret_ok = iir_valid_out && (inflight != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iir_data_in   <= '0;
      iir_valid_in  <= 1'b0;
      inflight      <= '0;
      issued_cnt    <= '0;
      err_underflow <= 1'b0;
    end else begin
      iir_valid_in <= issue;
      if (issue) begin
        iir_data_in <= fifo_rdata;
        issued_cnt  <= issued_cnt + 32'd1;
      end
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
      if (iir_valid_out && (inflight == '0)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_sample_feeder.sv
module tb_iir_sample_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int GAP   = 8;
  localparam int MAXI  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          flush = 1'b0;
  logic [DW-1:0] iir_data_in;
  logic          iir_valid_in;
  logic          iir_valid_out = 1'b0;
  logic [4:0]    level;
  logic [2:0]    inflight;
  logic [31:0]   issued_cnt;
  logic          err_underflow;

  always #5 clk = ~clk;

  iir_sample_feeder #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP), .MAX_INFLIGHT(MAXI)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .flush         (flush),
    .iir_data_in   (iir_data_in),
    .iir_valid_in  (iir_valid_in),
    .iir_valid_out (iir_valid_out),
    .level         (level),
    .inflight      (inflight),
    .issued_cnt    (issued_cnt),
    .err_underflow (err_underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue for the buffer, the time of the last issue
  // for pacing, and a plain integer for the outstanding count.
  int            cyc = 0;
  logic [DW-1:0] mq[$];
  int            m_last = -1000;
  int            m_inflight = 0;
  logic [31:0]   m_issued = '0;
  bit            m_err = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_live = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_last = -1000; m_inflight = 0; m_issued = '0;
      m_err = 0; m_valid = 0; m_data = '0; m_live = 1;
    end else begin
      bit rdy, iss, eret;
      rdy  = (mq.size() < DEPTH) && !flush;
      iss  = !flush && (mq.size() > 0) && (cyc - m_last >= GAP) && (m_inflight < MAXI);
      eret = iir_valid_out && (m_inflight > 0);
      if (iir_valid_out && m_inflight == 0) m_err = 1;
      m_valid = iss;
      if (iss) begin
        m_data = mq.pop_front();
        m_last = cyc;
        m_issued = m_issued + 32'd1;
      end
      m_inflight = m_inflight + int'(iss) - int'(eret);
      if (flush) begin
        mq.delete();
        m_last = -1000;
      end
      if (s_valid && rdy) mq.push_back(s_data);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("valid",    64'(iir_valid_in),  64'(m_valid));
      chk("data",     64'(iir_data_in),   64'(m_data));
      chk("level",    64'(level),         64'(mq.size()));
      chk("inflight", 64'(inflight),      64'(m_inflight));
      chk("issued",   64'(issued_cnt),    64'(m_issued));
      chk("err",      64'(err_underflow), 64'(m_err));
      chk("ready",    64'(s_ready),       64'((mq.size() < DEPTH) && !flush));
    end
  end

  int            pulse_cyc[$];
  logic [DW-1:0] pulse_dat[$];
  always @(negedge clk) begin
    if (iir_valid_in) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(iir_data_in);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && m_inflight == 0) begin
        done = 1;
        break;
      end
      iir_valid_out = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      step();
    end
    iir_valid_out = 1'b0;
    if (mq.size() == 0 && m_inflight == 0) done = 1;
    chk("drain_done", 64'(done), 64'd1);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 24'($urandom());
      step();
    end
    s_valid = 1'b0;
  endtask

  logic [DW-1:0] vals [5];
  int            max_if;

  initial begin
    vals = '{24'hFFFFFF, 24'h000002, 24'hFFFFFD, 24'h000004, 24'hFFFFFB};

    // Reset values
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", 64'(iir_valid_in), 64'd0);
    chk("rst_data",  64'(iir_data_in),  64'd0);
    chk("rst_level", 64'(level),        64'd0);
    chk("rst_if",    64'(inflight),     64'd0);
    chk("rst_iss",   64'(issued_cnt),   64'd0);
    chk("rst_err",   64'(err_underflow), 64'd0);
    rst_n = 1'b1;
    step();

    // Single-word latency
    s_data = 24'h7FFFFF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat_level1", 64'(level), 64'd1);
    chk("lat_nopulse", 64'(iir_valid_in), 64'd0);
    step();
    @(negedge clk);
    chk("lat_pulse", 64'(iir_valid_in), 64'd1);
    chk("lat_data",  64'(iir_data_in),  64'h7FFFFF);
    chk("lat_if",    64'(inflight),     64'd1);
    chk("lat_iss",   64'(issued_cnt),   64'd1);
    step();
    @(negedge clk);
    chk("lat_single", 64'(iir_valid_in), 64'd0);
    iir_valid_out = 1'b1;
    step();
    iir_valid_out = 1'b0;
    @(negedge clk);
    chk("lat_ret_if", 64'(inflight), 64'd0);

    // GAP spacing with immediate returns
    pulse_cyc.delete(); pulse_dat.delete();
    max_if = 0;
    for (int i = 0; i < 60; i++) begin
      if (i < 5) begin s_valid = 1'b1; s_data = vals[i]; end
      else s_valid = 1'b0;
      step();
      iir_valid_out = iir_valid_in;
      if (int'(inflight) > max_if) max_if = int'(inflight);
    end
    iir_valid_out = 1'b0;
    chk("gap_npulse", 64'(pulse_cyc.size()), 64'd5);
    for (int i = 0; i < 5 && i < pulse_cyc.size(); i++) begin
      chk("gap_data", 64'(pulse_dat[i]), 64'(vals[i]));
      if (i > 0) chk("gap_space", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'(GAP));
    end
    chk("gap_maxif", 64'(max_if <= 1), 64'd1);
    drain();

    // In-flight limit
    pulse_cyc.delete(); pulse_dat.delete();
    push_n(10);
    repeat (80) step();
    @(negedge clk);
    chk("lim_if",     64'(inflight), 64'd4);
    chk("lim_level",  64'(level),    64'd6);
    chk("lim_npulse", 64'(pulse_cyc.size()), 64'd4);
    iir_valid_out = 1'b1;
    step();
    iir_valid_out = 1'b0;
    @(negedge clk);
    chk("lim_wait", 64'(iir_valid_in), 64'd0);
    step();
    @(negedge clk);
    chk("lim_5th",    64'(iir_valid_in), 64'd1);
    chk("lim_if2",    64'(inflight),     64'd4);
    chk("lim_level2", 64'(level),        64'd5);
    drain();

    // Issue and return on the same edge
    push_n(2);
    repeat (30) step();
    @(negedge clk);
    chk("same_pre_if", 64'(inflight), 64'd2);
    s_valid = 1'b1; s_data = 24'h123456;
    step();
    s_valid = 1'b0;
    iir_valid_out = 1'b1;
    step();
    iir_valid_out = 1'b0;
    @(negedge clk);
    chk("same_pulse", 64'(iir_valid_in), 64'd1);
    chk("same_if",    64'(inflight),     64'd2);
    drain();

    // Fill to full, then flush
    push_n(4);
    repeat (40) step();
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 24'($urandom());
      step();
    end
    @(negedge clk);
    chk("full_level", 64'(level),   64'd16);
    chk("full_ready", 64'(s_ready), 64'd0);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(s_ready), 64'd0);
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("flush_level", 64'(level),      64'd0);
    chk("flush_if",    64'(inflight),   64'd4);
    chk("flush_iss",   64'(issued_cnt), 64'd23);
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = 24'($urandom());
      iir_valid_out = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 99) == 0);
      step();
    end
    s_valid = 1'b0; flush = 1'b0; iir_valid_out = 1'b0;
    drain();

    // Underflow
    @(negedge clk);
    chk("uf_pre", 64'(err_underflow), 64'd0);
    iir_valid_out = 1'b1;
    step();
    iir_valid_out = 1'b0;
    @(negedge clk);
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_if",  64'(inflight),      64'd0);
    repeat (5) step();
    @(negedge clk);
    chk("uf_sticky", 64'(err_underflow), 64'd1);

    // Reset while in GAPWAIT
    push_n(1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mrst_valid", 64'(iir_valid_in),  64'd0);
    chk("mrst_data",  64'(iir_data_in),   64'd0);
    chk("mrst_level", 64'(level),         64'd0);
    chk("mrst_if",    64'(inflight),      64'd0);
    chk("mrst_iss",   64'(issued_cnt),    64'd0);
    chk("mrst_err",   64'(err_underflow), 64'd0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("mrst_ready", 64'(s_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
